// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Package name is if_pkg; imported by fetch_queue and instr_fetch.
package if_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // One fetch-queue slot: the word returned by the ROM and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

    // Fetch targets are word aligned; the low two bits are simply dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fetch_queue.sv
// fetch_queue: synchronous FIFO of fq_entry_t with push/pop/flush.
// Pointers carry one extra MSB so full and empty are distinguishable
// without a separate occupancy register. The head is read combinationally.
module fetch_queue
    import if_pkg::*;
#(
    parameter int FQ_DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    input  fq_entry_t                 push_data_i,
    output fq_entry_t                 head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(FQ_DEPTH):0] count_o
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fq_entry_t   mem_q [FQ_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Guard against overflow/underflow locally even though the owner already qualifies these.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer next-state; flush empties the queue by snapping write onto read,
    // which leaves the head storage (and so the head outputs) unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = rd_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer and storage registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (!flush_i && do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage. Owns the PC, drives the ROM address combinationally,
// queues {pc, instr} pairs in fetch_queue and hands the head to decode over valid/ready.
// A redirect flushes the queue and reloads the PC (word aligned); a misaligned target
// sets a sticky error flag that only reset clears.
// Optional build macro IF_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module instr_fetch
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] instr_addr,
    input  logic [ILEN-1:0] instr_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            misalign_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            misalign_q, misalign_d;
    logic            push;
    logic            pop;
    logic            fq_full;
    logic            fq_empty;
    logic [CW-1:0]   fq_count;
    fq_entry_t       fq_head;
    fq_entry_t       fq_in;

    // Redirect wins over everything: head is hidden and nothing enters the queue.
    assign if_valid   = !fq_empty && !redirect_valid;
    assign pop        = if_valid && if_ready;
    assign push       = !redirect_valid && (!fq_full || pop);

    assign instr_addr = fetch_pc_q;
    assign fq_in      = '{pc: fetch_pc_q, instr: instr_data};
    assign if_instr   = fq_head.instr;
    assign if_pc      = fq_head.pc;
    assign misalign_err = misalign_q;

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_data_i (fq_in),
        .head_o      (fq_head),
        .full_o      (fq_full),
        .empty_o     (fq_empty),
        .count_o     (fq_count)
    );

    // PC and sticky-error next state; the PC wraps naturally at the top of the address space.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    // PC and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;

    // Count every push, and every entry thrown away by a redirect; both wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'd0, push};
            if (redirect_valid) begin
                perf_flushed_q <= perf_flushed_q + 32'(fq_count);
            end
        end
    end
`else
    // Occupancy is only consumed by the perf counters.
    logic unused_fq_count;
    assign unused_fq_count = ^fq_count;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: default-reset instance plus a second
// instance with RESET_PC near the top of the address space to exercise wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_addr, instr_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        misalign_err;

    logic [31:0] w_instr_addr, w_instr_data;
    logic        w_if_valid;
    logic        w_if_ready;
    logic [31:0] w_if_instr, w_if_pc;
    logic        w_misalign_err;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
    logic [31:0] w_perf_fetched, w_perf_flushed;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0011_0233;
        return {~a[15:0], a[15:0]};
    endfunction

    assign instr_data   = rom(instr_addr);
    assign w_instr_data = rom(w_instr_addr);

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .instr_addr     (instr_addr),
        .instr_data     (instr_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    instr_fetch #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .clk            (clk),
        .reset          (reset),
        .instr_addr     (w_instr_addr),
        .instr_data     (w_instr_data),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .if_valid       (w_if_valid),
        .if_ready       (w_if_ready),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc),
        .misalign_err   (w_misalign_err)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (w_perf_fetched),
        .perf_flushed   (w_perf_flushed)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 after reset, with reset already released.
    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        if_ready = 1'b1;
        w_if_ready = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc = 32'h0;

        // 1: basic latency with decode always ready
        do_reset(); #1;
        chk("t1_c0_addr",  instr_addr, 32'h0);
        chk("t1_c0_valid", {31'd0, if_valid}, 32'd0);
        chk("t1_c0_pc",    if_pc, 32'h0);
        chk("t1_c0_instr", if_instr, 32'h0);
        chk("t1_c0_mis",   {31'd0, misalign_err}, 32'd0);
        next_cycle();
        chk("t1_c1_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_c1_pc",    if_pc, 32'h0);
        chk("t1_c1_instr", if_instr, 32'h0011_0233);
        next_cycle();
        chk("t1_c2_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_c2_pc",    if_pc, 32'h4);
        chk("t1_c2_instr", if_instr, rom(32'h4));

        // 2: backpressure fills the queue, then back-to-back drain
        if_ready = 1'b0;
        do_reset(); #1;
        chk("t2_c0_addr",  instr_addr, 32'h0);
        chk("t2_c0_valid", {31'd0, if_valid}, 32'd0);
        next_cycle();
        chk("t2_c1_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_c1_addr",  instr_addr, 32'h4);
        next_cycle();
        chk("t2_c2_addr",  instr_addr, 32'h8);
        chk("t2_c2_pc",    if_pc, 32'h0);
        next_cycle();
        next_cycle();
        chk("t2_c4_addr",  instr_addr, 32'h8);
        chk("t2_c4_pc",    if_pc, 32'h0);
        chk("t2_c4_valid", {31'd0, if_valid}, 32'd1);
        next_cycle();
        if_ready = 1'b1; #1;
        chk("t2_d0_pc", if_pc, 32'h0);
        chk("t2_d0_v",  {31'd0, if_valid}, 32'd1);
        next_cycle();
        chk("t2_d1_pc", if_pc, 32'h4);
        chk("t2_d1_v",  {31'd0, if_valid}, 32'd1);
        next_cycle();
        chk("t2_d2_pc", if_pc, 32'h8);
        chk("t2_d2_v",  {31'd0, if_valid}, 32'd1);
        chk("t2_d2_instr", if_instr, rom(32'h8));
        next_cycle();
        chk("t2_d3_pc", if_pc, 32'hC);
        chk("t2_d3_v",  {31'd0, if_valid}, 32'd1);

        // 3: redirect while full; queued PC 4 must never be offered
        if_ready = 1'b0;
        do_reset();
        next_cycle();
        next_cycle();
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10; #1;
        chk("t3_r0_valid", {31'd0, if_valid}, 32'd0);
        next_cycle();
        redirect_valid = 1'b0; #1;
        chk("t3_r1_valid", {31'd0, if_valid}, 32'd0);
        chk("t3_r1_addr",  instr_addr, 32'h10);
        next_cycle();
        chk("t3_r2_valid", {31'd0, if_valid}, 32'd1);
        chk("t3_r2_pc",    if_pc, 32'h10);
        chk("t3_r2_instr", if_instr, rom(32'h10));

        // 4: misaligned redirect, sticky error, reset clears it
        redirect_valid = 1'b1;
        redirect_pc = 32'h13; #1;
        chk("t4_pre_mis", {31'd0, misalign_err}, 32'd0);
        next_cycle();
        redirect_valid = 1'b0; #1;
        chk("t4_addr", instr_addr, 32'h10);
        chk("t4_mis",  {31'd0, misalign_err}, 32'd1);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        next_cycle();
        redirect_valid = 1'b0; #1;
        chk("t4_addr2", instr_addr, 32'h20);
        chk("t4_mis2",  {31'd0, misalign_err}, 32'd1);
        next_cycle();
        chk("t4_pc2",   if_pc, 32'h20);
        do_reset(); #1;
        chk("t4_rst_mis", {31'd0, misalign_err}, 32'd0);

        // 5: wrap from the top of the address space (second instance, same reset)
        chk("t5_c0_addr", w_instr_addr, 32'hFFFF_FFF8);
        chk("t5_c0_valid", {31'd0, w_if_valid}, 32'd0);
        next_cycle();
        chk("t5_c1_pc", w_if_pc, 32'hFFFF_FFF8);
        next_cycle();
        chk("t5_c2_pc", w_if_pc, 32'hFFFF_FFFC);
        next_cycle();
        chk("t5_c3_pc", w_if_pc, 32'h0000_0000);
        chk("t5_c3_v",  {31'd0, w_if_valid}, 32'd1);

        // 6: reset mid-operation with a full queue
        if_ready = 1'b0;
        do_reset();
        next_cycle();
        next_cycle();
        chk("t6_full_valid", {31'd0, if_valid}, 32'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; #1;
        chk("t6_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_addr",  instr_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("t6_perf_fetched0", perf_fetched, 32'd0);
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        next_cycle();
        redirect_valid = 1'b0; #1;
        chk("t6_perf_flushed", perf_flushed, 32'd2);
        chk("t6_perf_fetched", perf_fetched, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
